// File: rtl/za_tile_sequencer_if.sv
// rtl/za_tile_sequencer_if.sv - command, operand, ZA port and compute-unit bundle for the ZA tile sequencer
interface za_tile_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 512
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_rows;
    logic              za_enabled;
    logic              opnd_valid;
    logic              opnd_ready;
    logic [ADDR_W-1:0] za_addr;
    logic [DATA_W-1:0] za_rdata;
    logic              za_write_en;
    logic [DATA_W-1:0] za_wdata;
    logic [DATA_W-1:0] acc_in;
    logic              fmla_en;
    logic              fmopa_en;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   rows_done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_rows, za_enabled, opnd_valid, za_rdata, result,
        output cmd_ready, opnd_ready, za_addr, za_write_en, za_wdata, acc_in,
               fmla_en, fmopa_en, busy, done, err, rows_done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_rows, za_enabled, opnd_valid, za_rdata, result,
        input  cmd_ready, opnd_ready, za_addr, za_write_en, za_wdata, acc_in,
               fmla_en, fmopa_en, busy, done, err, rows_done
    );
endinterface

// File: rtl/za_tile_sequencer.sv
// rtl/za_tile_sequencer.sv - multi-row FMLA/FMOPA sequencer: ZA read, operand issue, compute wait, ZA write-back
module za_tile_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 512,
    parameter int MAC_LAT = 1
) (
    input logic clk,
    input logic rst,
    za_tile_sequencer_if.slave bus
);
    localparam int CNT_W = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
    localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WB} state_t;

    state_t            state, state_nxt;
    logic              op_r;
    logic [ADDR_W-1:0] row_r;
    logic [ADDR_W:0]   rows_r;
    logic [ADDR_W:0]   rows_done_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  wait_cnt;
    logic              done_r;
    logic              err_r;

    logic accept, legal, abort, fire, last;

    // accept mirrors cmd_ready without rst; rst already forces the state register
    assign accept = bus.cmd_valid && (state == IDLE) && bus.za_enabled;
    assign legal  = (bus.cmd_rows != '0) && (bus.cmd_rows <= MAX_ROWS);
    assign abort  = (state != IDLE) && !bus.za_enabled;
    assign fire   = (state == ISSUE) && bus.za_enabled && bus.opnd_valid;
    assign last   = (rows_done_r + 1'b1) == rows_r;

    always_comb begin
        state_nxt       = state;
        bus.cmd_ready   = (state == IDLE) && bus.za_enabled && !rst;
        bus.opnd_ready  = (state == ISSUE) && bus.za_enabled;
        bus.fmla_en     = fire && !op_r;
        bus.fmopa_en    = fire && op_r;
        bus.za_addr     = row_r;
        bus.za_write_en = (state == WB) && bus.za_enabled;
        bus.za_wdata    = bus.result;
        bus.acc_in      = acc_r;
        bus.busy        = (state != IDLE);
        bus.done        = done_r;
        bus.err         = err_r;
        bus.rows_done   = rows_done_r;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && legal) state_nxt = FETCH;
                FETCH:   state_nxt = ISSUE;
                ISSUE:   if (bus.opnd_valid) state_nxt = (MAC_LAT == 1) ? WB : WAIT;
                WAIT:    if (wait_cnt == '0) state_nxt = WB;
                WB:      state_nxt = last ? IDLE : FETCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_r        <= 1'b0;
            row_r       <= '0;
            rows_r      <= '0;
            rows_done_r <= '0;
            acc_r       <= '0;
            wait_cnt    <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == WB) && bus.za_enabled && last;
            err_r  <= (accept && !legal) || abort;

            if (accept) begin
                op_r        <= bus.cmd_op;
                row_r       <= bus.cmd_base;
                rows_r      <= bus.cmd_rows;
                rows_done_r <= '0;
            end

            if ((state == FETCH) && bus.za_enabled)
                acc_r <= bus.za_rdata;

            if (fire)
                wait_cnt <= CNT_W'(MAC_LAT - 2);
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 1'b1;

            // row address wraps naturally at 2**ADDR_W
            if ((state == WB) && bus.za_enabled) begin
                rows_done_r <= rows_done_r + 1'b1;
                row_r       <= row_r + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_za_tile_sequencer.sv
// tb/tb_za_tile_sequencer.sv - scoreboard bench for za_tile_sequencer with ZA memory and compute-unit models
module tb_za_tile_sequencer;
    localparam int AW  = 8;
    localparam int DW  = 512;
    localparam int LAT = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    za_tile_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    za_tile_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAC_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    wr_t exp_q[$];

    int n_wr = 0, n_fmla = 0, n_fmopa = 0, n_hs = 0, n_done = 0, n_err = 0;
    int stall_row_cfg = 255;
    int stall_len_cfg = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 16) ? DW'(5) : DW'(i * 7 + 1);
    endfunction

    // ZA storage: combinational read, write on the strobe, reloaded while rst is high
    logic [DW-1:0] za_mem [256];
    assign bus.za_rdata = za_mem[bus.za_addr];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) za_mem[i] <= init_val(i);
        end else if (bus.za_write_en) begin
            za_mem[bus.za_addr] <= bus.za_wdata;
        end
    end

    // operand source: pair k of a command is (3+k, 4+k); optional stall before one pair
    logic [7:0]    hs_k;
    int            stall_left;
    logic [DW-1:0] op_a, op_b;
    assign op_a = DW'(hs_k) + DW'(3);
    assign op_b = DW'(hs_k) + DW'(4);
    assign bus.opnd_valid = !((stall_left > 0) && (int'(hs_k) == stall_row_cfg));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_k       <= 8'd0;
            stall_left <= 0;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            hs_k       <= 8'd0;
            stall_left <= stall_len_cfg;
        end else begin
            if (bus.opnd_valid && bus.opnd_ready) hs_k <= hs_k + 8'd1;
            if (bus.opnd_ready && !bus.opnd_valid && stall_left > 0) stall_left <= stall_left - 1;
        end
    end

    // compute unit: FMLA gives acc + a*b, FMOPA gives acc + 2*a*b, LAT-deep pipeline
    logic [DW-1:0] pipe [LAT];
    assign bus.result = pipe[LAT-1];
    always @(posedge clk) begin
        if (bus.fmla_en)       pipe[0] <= bus.acc_in + op_a * op_b;
        else if (bus.fmopa_en) pipe[0] <= bus.acc_in + DW'(2) * op_a * op_b;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("onehot_en", DW'(bus.fmla_en & bus.fmopa_en), DW'(0));
            check_eq("en_vs_handshake", DW'(bus.fmla_en | bus.fmopa_en), DW'(bus.opnd_valid & bus.opnd_ready));
            check_eq("done_and_err", DW'(bus.done & bus.err), DW'(0));
            if (bus.fmla_en) n_fmla++;
            if (bus.fmopa_en) n_fmopa++;
            if (bus.opnd_valid && bus.opnd_ready) n_hs++;
            if (bus.done) n_done++;
            if (bus.err) n_err++;
            if (bus.za_write_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write_addr", DW'(bus.za_addr), DW'(-1));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_eq("wb_addr", DW'(bus.za_addr), DW'(e.addr));
                    check_eq("wb_data", bus.za_wdata, e.data);
                end
            end
        end
    end

    task automatic send(input logic op, input logic [AW-1:0] base, input logic [AW:0] rows);
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_rows  = rows;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        check_eq("cmd_ready_wait", DW'(bus.cmd_ready), DW'(1));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic op, input logic [AW-1:0] base, input int rows);
        for (int i = 0; i < rows; i++) begin
            wr_t e;
            e.addr = base + AW'(i);
            e.data = za_mem[e.addr] + DW'((3 + i) * (4 + i) * (op ? 2 : 1));
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input logic op, input logic [AW-1:0] base, input int rows,
                       input int srow, input int slen);
        int n;
        int f0, p0, h0;
        stall_row_cfg = srow;
        stall_len_cfg = slen;
        f0 = n_fmla; p0 = n_fmopa; h0 = n_hs;
        push_exp(op, base, rows);
        send(op, base, AW'(rows) | ((rows == 256) ? 9'h100 : 9'h000));
        n = 0;
        while (!bus.done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_latency", DW'(n), DW'(rows * (LAT + 2) + slen));
        check_eq("rows_done", DW'(bus.rows_done), DW'(rows));
        check_eq("busy_after_done", DW'(bus.busy), DW'(0));
        check_eq("cmd_ready_after_done", DW'(bus.cmd_ready), DW'(1));
        check_eq("fmla_pulses", DW'(n_fmla - f0), DW'(op ? 0 : rows));
        check_eq("fmopa_pulses", DW'(n_fmopa - p0), DW'(op ? rows : 0));
        check_eq("handshakes", DW'(n_hs - h0), DW'(rows));
        check_eq("queue_drained", DW'(exp_q.size()), DW'(0));
        stall_row_cfg = 255;
        stall_len_cfg = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, d0;
        logic [AW:0] bad_rows [2];
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_rows   = '0;
        bus.za_enabled = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", DW'(bus.cmd_ready), DW'(0));
        check_eq("rst_busy", DW'(bus.busy), DW'(0));
        check_eq("rst_done", DW'(bus.done), DW'(0));
        check_eq("rst_err", DW'(bus.err), DW'(0));
        check_eq("rst_za_addr", DW'(bus.za_addr), DW'(0));
        check_eq("rst_acc_in", bus.acc_in, DW'(0));
        check_eq("rst_rows_done", DW'(bus.rows_done), DW'(0));
        check_eq("rst_opnd_ready", DW'(bus.opnd_ready), DW'(0));
        check_eq("rst_write_en", DW'(bus.za_write_en), DW'(0));
        check_eq("rst_enables", DW'({bus.fmla_en, bus.fmopa_en}), DW'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("cmd_ready_idle", DW'(bus.cmd_ready), DW'(1));

        run(1'b0, 8'h10, 1, 255, 0);
        check_eq("za_10_fmla", za_mem[8'h10], DW'(17));

        run(1'b1, 8'hFE, 3, 255, 0);

        run(1'b0, 8'h20, 4, 1, 2);

        bad_rows[0] = 9'd0;
        bad_rows[1] = 9'd300;
        for (int b = 0; b < 2; b++) begin
            w0 = n_wr; e0 = n_err;
            send(1'b0, 8'h30, bad_rows[b]);
            check_eq("illegal_err_pulse", DW'(bus.err), DW'(1));
            check_eq("illegal_busy", DW'(bus.busy), DW'(0));
            check_eq("illegal_rows_done", DW'(bus.rows_done), DW'(0));
            repeat (3) begin
                @(posedge clk); #1;
                check_eq("illegal_busy_hold", DW'(bus.busy), DW'(0));
            end
            check_eq("illegal_err_count", DW'(n_err - e0), DW'(1));
            check_eq("illegal_no_write", DW'(n_wr - w0), DW'(0));
        end

        d0 = n_done; e0 = n_err;
        push_exp(1'b0, 8'h40, 1);
        send(1'b0, 8'h40, 9'd4);
        repeat (2 * LAT + 3) @(posedge clk);
        #1;
        bus.za_enabled = 1'b0;
        #1;
        check_eq("abort_busy_in_wb", DW'(bus.busy), DW'(1));
        check_eq("abort_write_suppressed", DW'(bus.za_write_en), DW'(0));
        @(posedge clk); #1;
        check_eq("abort_err", DW'(bus.err), DW'(1));
        check_eq("abort_idle", DW'(bus.busy), DW'(0));
        check_eq("abort_rows_done", DW'(bus.rows_done), DW'(1));
        bus.za_enabled = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_no_done", DW'(n_done - d0), DW'(0));
        check_eq("abort_err_count", DW'(n_err - e0), DW'(1));
        check_eq("abort_queue", DW'(exp_q.size()), DW'(0));
        check_eq("abort_row41_untouched", za_mem[8'h41], init_val(8'h41));

        d0 = n_done; e0 = n_err;
        send(1'b0, 8'h50, 9'd2);
        repeat (2) @(posedge clk);
        #1;
        check_eq("wait_busy", DW'(bus.busy), DW'(1));
        rst = 1'b1;
        #1;
        check_eq("arst_busy", DW'(bus.busy), DW'(0));
        check_eq("arst_cmd_ready", DW'(bus.cmd_ready), DW'(0));
        check_eq("arst_za_addr", DW'(bus.za_addr), DW'(0));
        check_eq("arst_acc_in", bus.acc_in, DW'(0));
        check_eq("arst_rows_done", DW'(bus.rows_done), DW'(0));
        check_eq("arst_outputs", DW'({bus.opnd_ready, bus.za_write_en, bus.fmla_en, bus.fmopa_en, bus.done, bus.err}), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_cmd_ready", DW'(bus.cmd_ready), DW'(1));
        check_eq("post_rst_no_done_err", DW'((n_done - d0) + (n_err - e0)), DW'(0));
        run(1'b0, 8'h10, 1, 255, 0);
        check_eq("post_rst_za_10", za_mem[8'h10], DW'(17));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
